// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: rotate / logical / arithmetic / reverse-rotate, valid-ready handshake.
// Optional zero/lost status outputs are enabled with `define BSHIFT_STATUS_EN.
module pipelined_barrel_shifter #(
  parameter int WIDTH     = 32,
  parameter int REG_EVERY = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WIDTH-1:0]          data,
  input  logic [$clog2(WIDTH)-1:0]  shiftAmt,
  input  logic                      lr,
  input  logic [1:0]                mode,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [WIDTH-1:0]          y,
  output logic                      out_valid,
  input  logic                      out_ready
`ifdef BSHIFT_STATUS_EN
  ,
  output logic                      zero,
  output logic                      lost
`endif
);

  localparam int AW = $clog2(WIDTH);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] data;
    logic [AW-1:0]    amt;
    logic             lr;
    logic [1:0]       mode;
    logic             fill;
    logic             lost;
  } slot_t;

  logic  adv;
  slot_t slot_in;
  slot_t last_o;
  slot_t last_d;

  function automatic slot_t shift_level(input slot_t s, input int unsigned k);
    slot_t            r;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] lo_mask;
    logic [WIDTH-1:0] hi_mask;
    int unsigned      sh;
    r       = s;
    sh      = 32'd1 << k;
    d       = s.data;
    lo_mask = {WIDTH{1'b1}} >> (WIDTH - sh);
    hi_mask = ~({WIDTH{1'b1}} >> sh);
    if (s.amt[k]) begin
      if (s.mode == 2'b00 || s.mode == 2'b11) begin
        r.data = s.lr ? ((d >> sh) | (d << (WIDTH - sh)))
                      : ((d << sh) | (d >> (WIDTH - sh)));
      end else if (s.lr) begin
        r.data = (d >> sh) | (s.fill ? hi_mask : '0);
        r.lost = s.lost | (|(d & lo_mask));
      end else begin
        r.data = d << sh;
        r.lost = s.lost | (|(d & hi_mask));
      end
    end
    return r;
  endfunction

  // Idle slots are zeroed so bubbles carry no stale data down the pipe.
  always_comb begin
    slot_in = '0;
    if (in_valid) begin
      slot_in.valid = 1'b1;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        slot_in.data[i] = (mode == 2'b11) ? data[WIDTH-1-i] : data[i];
      end
      slot_in.amt  = shiftAmt;
      slot_in.lr   = lr;
      slot_in.mode = mode;
      slot_in.fill = (mode == 2'b10) & lr & data[WIDTH-1];
    end
  end

  for (genvar k = 0; k < AW; k++) begin : g_lvl
    slot_t src;
    slot_t stage_d;
    slot_t stage_o;

    if (k == 0) begin : g_first
      always_comb src = slot_in;
    end else begin : g_next
      always_comb src = g_lvl[k-1].stage_o;
    end

    always_comb stage_d = shift_level(src, k);

    if (((k + 1) % REG_EVERY == 0) || (k == AW - 1)) begin : g_reg
      slot_t stage_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   stage_q <= '0;
        else if (adv) stage_q <= stage_d;
      end
      always_comb stage_o = stage_q;
    end else begin : g_comb
      always_comb stage_o = stage_d;
    end
  end

  always_comb begin
    last_o    = g_lvl[AW-1].stage_o;
    last_d    = g_lvl[AW-1].stage_d;
    y         = last_o.data;
    out_valid = last_o.valid;
    adv       = out_ready | ~out_valid;
    in_ready  = adv;
  end

`ifdef BSHIFT_STATUS_EN
  logic zero_q;
  logic zero_d;

  always_comb zero_d = last_d.valid && (last_d.data == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   zero_q <= 1'b0;
    else if (adv) zero_q <= zero_d;
  end

  always_comb begin
    zero = zero_q;
    lost = last_o.lost;
  end

  logic unused_bits;
  always_comb unused_bits = ^{last_o.amt, last_o.lr, last_o.mode, last_o.fill, last_d};
`else
  logic unused_bits;
  always_comb unused_bits = ^{last_o.amt, last_o.lr, last_o.mode, last_o.fill, last_o.lost, last_d};
`endif

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboarded bench for pipelined_barrel_shifter (WIDTH=32/REG_EVERY=1 plus a WIDTH=8/REG_EVERY=3 instance).
module tb_pipelined_barrel_shifter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] data;
  logic [4:0]  shiftAmt;
  logic        lr;
  logic [1:0]  mode;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] y;
  logic        out_valid;
  logic        out_ready;

  logic [7:0]  d8;
  logic [2:0]  amt8;
  logic        lr8;
  logic [1:0]  mode8;
  logic        in_valid8;
  logic        in_ready8;
  logic [7:0]  y8;
  logic        out_valid8;
  logic        out_ready8;
`ifdef BSHIFT_STATUS_EN
  logic        zero, lost, zero8, lost8;
`endif

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] exp;
    int          t;
    bit          lat;
  } sb_t;
  sb_t sb_q[$];

  bit          bp_en = 1'b0;
  int          bp_i  = 0;
  bit          stalled_prev = 1'b0;
  logic [31:0] y_prev;

  pipelined_barrel_shifter #(.WIDTH(32), .REG_EVERY(1)) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .shiftAmt(shiftAmt), .lr(lr), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .y(y), .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef BSHIFT_STATUS_EN
    , .zero(zero), .lost(lost)
`endif
  );

  pipelined_barrel_shifter #(.WIDTH(8), .REG_EVERY(3)) dut8 (
    .clk(clk), .rst_n(rst_n), .data(d8), .shiftAmt(amt8), .lr(lr8), .mode(mode8),
    .in_valid(in_valid8), .in_ready(in_ready8), .y(y8), .out_valid(out_valid8),
    .out_ready(out_ready8)
`ifdef BSHIFT_STATUS_EN
    , .zero(zero8), .lost(lost8)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // out_ready pattern 1,0,0,1 while backpressure is enabled
  always @(negedge clk) begin
    if (bp_en) begin
      out_ready = (bp_i % 4 == 0 || bp_i % 4 == 3);
      bp_i++;
    end
  end

  // Monitor: pops the scoreboard on every transfer, checks stall stability.
  always begin
    sb_t e;
    @(negedge clk);
    #2;
    if (rst_n) begin
      if (stalled_prev) begin
        chk("stall_y_hold", y, y_prev);
        chk("stall_valid_hold", {31'd0, out_valid}, 32'd1);
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("stray_result", y, 32'hxxxx_xxxx);
        end else begin
          e = sb_q.pop_front();
          chk("result", y, e.exp);
          if (e.lat) chk("latency", cyc - e.t, 32'd5);
        end
      end
      stalled_prev = out_valid && !out_ready;
      y_prev = y;
    end else begin
      stalled_prev = 1'b0;
    end
  end

  task automatic send(input logic [31:0] d, input logic [4:0] a, input logic l,
                      input logic [1:0] m, input logic [31:0] exp, input bit lat);
    sb_t e;
    bit done = 1'b0;
    for (int tries = 0; tries < 50 && !done; tries++) begin
      @(negedge clk);
      data = d; shiftAmt = a; lr = l; mode = m; in_valid = 1'b1;
      #1;
      if (in_ready) begin
        e.exp = exp; e.t = cyc; e.lat = lat;
        sb_q.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
    end
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
    chk("drain_empty", sb_q.size(), 32'd0);
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] d, input int s);
    logic [63:0] w;
    w = {d, d} << s;
    return w[63:32];
  endfunction

  initial begin
    rst_n = 1'b0; data = '0; shiftAmt = '0; lr = 1'b0; mode = '0;
    in_valid = 1'b0; out_ready = 1'b1;
    d8 = '0; amt8 = '0; lr8 = 1'b0; mode8 = '0; in_valid8 = 1'b0; out_ready8 = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_y", y, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

    // mid-stream reset with 3 in flight
    send(32'h44238108, 5'd1, 1'b0, 2'b00, 32'h0, 1'b0);
    send(32'h44238108, 5'd2, 1'b0, 2'b00, 32'h0, 1'b0);
    send(32'h44238108, 5'd3, 1'b0, 2'b00, 32'h0, 1'b0);
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midreset_y", y, 32'd0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // directed modes
    send(32'h44238108, 5'd1, 1'b0, 2'b00, 32'h88470210, 1'b1);
    drain();
    send(32'h44238108, 5'd4, 1'b1, 2'b00, 32'h84423810, 1'b0);
    send(32'h44238108, 5'd8, 1'b1, 2'b01, 32'h00442381, 1'b0);
    send(32'h84000000, 5'd4, 1'b1, 2'b10, 32'hF8400000, 1'b0);
    send(32'h84000000, 5'd4, 1'b0, 2'b10, 32'h40000000, 1'b0);
    send(32'h44238108, 5'd0, 1'b0, 2'b11, 32'h1081C422, 1'b0);
    send(32'h44238108, 5'd4, 1'b1, 2'b11, 32'h21081C42, 1'b0);
    send(32'h44238108, 5'd31, 1'b0, 2'b01, 32'h00000000, 1'b0);
    send(32'h44238109, 5'd31, 1'b0, 2'b01, 32'h80000000, 1'b0);
    send(32'h44238108, 5'd0, 1'b1, 2'b01, 32'h44238108, 1'b0);
    drain();

    // backpressure stream
    bp_en = 1'b1;
    for (int i = 0; i < 8; i++) send(32'h44238108, i[4:0], 1'b0, 2'b00, rotl(32'h44238108, i), 1'b0);
    drain();
    bp_en = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;

    // WIDTH=8, REG_EVERY=3: single stage
    @(negedge clk);
    d8 = 8'h81; amt8 = 3'd1; lr8 = 1'b0; mode8 = 2'b00; in_valid8 = 1'b1;
    @(negedge clk);
    in_valid8 = 1'b0;
    chk("w8_valid", {31'd0, out_valid8}, 32'd1);
    chk("w8_rot", {24'd0, y8}, 32'h03);
    d8 = 8'h81; amt8 = 3'd1; lr8 = 1'b0; mode8 = 2'b01; in_valid8 = 1'b1;
    @(negedge clk);
    in_valid8 = 1'b0;
    chk("w8_lsl", {24'd0, y8}, 32'h02);
`ifdef BSHIFT_STATUS_EN
    chk("w8_lost", {31'd0, lost8}, 32'd1);
    chk("w8_zero", {31'd0, zero8}, 32'd0);
`endif
    @(negedge clk);
    chk("w8_bubble", {31'd0, out_valid8}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
